// File: rtl/mips_pc_sequencer.sv
// mips_pc_sequencer: program-counter sequencer for a small MIPS core.
// It holds the instruction address, selects the next PC (jump, taken branch
// or sequential) and gates commits through core_en. A self-loop, where
// next_pc equals the current address, stops execution and sets the sticky
// spin_halt flag.
// Optional feature: define MIPS_SEQ_STEP_EN to enable single-stepping from
// HALT through the step input. When it is undefined, step is ignored and
// STEP is never entered.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | out of reset, waits for start, no commits
//  RUN   | one instruction commits per clock, ReadAddr follows next_pc
//  HALT  | stopped after halt_req or a self-loop, ReadAddr held
//  STEP  | commits exactly one instruction, then returns to HALT
module mips_pc_sequencer #(
   parameter int              PC_W      = 8,
   parameter logic [PC_W-1:0] RESET_VEC = 8'h00
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            halt_req,
   input  logic            step,
   input  logic            Branch,
   input  logic            Zero,
   input  logic [31:0]     SEImm,
   input  logic            Jump,
   input  logic [25:0]     JumpValue,
   output logic [PC_W-1:0] ReadAddr,
   output logic            core_en,
   output logic [1:0]      state,
   output logic            spin_halt,
   output logic [15:0]     instr_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2,
      S_STEP = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [PC_W-1:0] pc_d;
   logic [15:0]     cnt_d;
   logic            spin_d;
   logic [PC_W-1:0] next_pc;
   logic [31:0]     branch_sum;
   logic            commit;

   // The upper jump-field bits lie above the address width, and step has no
   // function when single-stepping is compiled out.
   logic unused_bits;
   assign unused_bits = ^{step, JumpValue[25:PC_W-2]};

   // Branch target is formed at full immediate width, then truncated.
   assign branch_sum = 32'(ReadAddr) + 32'd4 + (SEImm << 2);

   // Outputs are registers; commit is a pure decode of the current state.
   assign commit  = (state_q == S_RUN) || (state_q == S_STEP);
   assign core_en = commit;
   assign state   = state_q;

   // Next-PC select: jump beats a taken branch, which beats sequential.
   always_comb begin
      next_pc = ReadAddr + PC_W'(4);
      if (Jump) begin
         next_pc = {JumpValue[PC_W-3:0], 2'b00};
      end else if (Branch && Zero) begin
         next_pc = branch_sum[PC_W-1:0];
      end
   end

   // Next-state and next-datapath values; core inputs matter only on commit.
   always_comb begin
      state_d = state_q;
      pc_d    = ReadAddr;
      cnt_d   = instr_count;
      spin_d  = spin_halt;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = RESET_VEC;
               cnt_d   = '0;
               spin_d  = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN, S_STEP: begin
            if (instr_count != 16'hFFFF) begin
               cnt_d = instr_count + 16'd1;
            end
            if (next_pc == ReadAddr) begin
               spin_d  = 1'b1;
               state_d = S_HALT;
            end else begin
               pc_d    = next_pc;
               state_d = ((state_q == S_STEP) || halt_req) ? S_HALT : S_RUN;
            end
         end
         S_HALT: begin
            if (start && !halt_req) begin
               spin_d  = 1'b0;
               state_d = S_RUN;
            end
`ifdef MIPS_SEQ_STEP_EN
            else if (step && !start) begin
               state_d = S_STEP;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, forced to reset values asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         ReadAddr    <= RESET_VEC;
         instr_count <= '0;
         spin_halt   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ReadAddr    <= pc_d;
         instr_count <= cnt_d;
         spin_halt   <= spin_d;
      end
   end

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// tb_mips_pc_sequencer: directed and randomized checks of the PC sequencer
// against a behavioural model that tracks the program counter as an integer.
module tb_mips_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, halt_req, step, branch, zero, jump;
   logic [31:0] se_imm;
   logic [25:0] jump_value;
   logic [7:0]  read_addr;
   logic        core_en;
   logic [1:0]  state;
   logic        spin_halt;
   logic [15:0] instr_count;

   int n_checks = 0;
   int n_errors = 0;

   // Model: 0 idle, 1 running, 2 halted, 3 single step.
   int m_state, m_pc, m_cnt;
   bit m_spin;
   int saved_cnt, pulses;

   always #5 clk = ~clk;

   mips_pc_sequencer #(.PC_W(8), .RESET_VEC(8'h00)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
      .step(step), .Branch(branch), .Zero(zero), .SEImm(se_imm),
      .Jump(jump), .JumpValue(jump_value), .ReadAddr(read_addr),
      .core_en(core_en), .state(state), .spin_halt(spin_halt),
      .instr_count(instr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic clr_in();
      start = 0; halt_req = 0; step = 0; branch = 0; zero = 0; jump = 0;
      se_imm = '0; jump_value = '0;
   endtask

   task automatic model_reset();
      m_state = 0; m_pc = 0; m_cnt = 0; m_spin = 0;
   endtask

   // Applies the sequencing rules for one rising edge using current inputs.
   task automatic model_edge();
      int nxt;
      bit step_en;
`ifdef MIPS_SEQ_STEP_EN
      step_en = 1;
`else
      step_en = 0;
`endif
      if (m_state == 1 || m_state == 3) begin
         if (jump)               nxt = (int'(jump_value) * 4) & 255;
         else if (branch && zero) nxt = (m_pc + 4 + int'($signed(se_imm)) * 4) & 255;
         else                    nxt = (m_pc + 4) & 255;
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (nxt == m_pc) begin
            m_spin = 1;
            m_state = 2;
         end else begin
            m_pc = nxt;
            m_state = (m_state == 3 || halt_req) ? 2 : 1;
         end
      end else if (m_state == 0) begin
         if (start) begin
            m_pc = 0; m_cnt = 0; m_spin = 0; m_state = 1;
         end
      end else begin
         if (start && !halt_req) begin
            m_spin = 0; m_state = 1;
         end else if (step_en && step && !start) begin
            m_state = 3;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"}, 32'(state), 32'(m_state));
      chk({tag, ".pc"}, 32'(read_addr), 32'(m_pc));
      chk({tag, ".core_en"}, 32'(core_en), 32'(m_state == 1 || m_state == 3));
      chk({tag, ".spin"}, 32'(spin_halt), 32'(m_spin));
      chk({tag, ".count"}, 32'(instr_count), 32'(m_cnt));
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic reset_pulse(input string tag);
      #2 reset_n = 0;
      model_reset();
      #2;
      chk({tag, ".state"}, 32'(state), 32'd0);
      chk({tag, ".pc"}, 32'(read_addr), 32'd0);
      chk({tag, ".core_en"}, 32'(core_en), 32'd0);
      chk({tag, ".spin"}, 32'(spin_halt), 32'd0);
      chk({tag, ".count"}, 32'(instr_count), 32'd0);
      #2 reset_n = 1;
   endtask

   initial begin
      clr_in();
      reset_n = 0;
      model_reset();
      #2;
      check_all("rst");
      chk("rst_pc", 32'(read_addr), 32'h00);
      @(posedge clk); #1;
      reset_n = 1;
      tick("idle0");
      tick("idle1");
      chk("idle_hold", 32'(state), 32'd0);

      start = 1; tick("start");
      chk("run_pc0", 32'(read_addr), 32'h00);
      chk("run_en0", 32'(core_en), 32'd1);
      start = 0;
      tick("seq1"); chk("seq_pc1", 32'(read_addr), 32'h04);
      tick("seq2"); chk("seq_pc2", 32'(read_addr), 32'h08);
      tick("seq3"); chk("seq_pc3", 32'(read_addr), 32'h0C);
      chk("seq_cnt3", 32'(instr_count), 32'd3);

      jump = 1; jump_value = 26'h6; tick("jmp18");
      chk("jmp_pc18", 32'(read_addr), 32'h18);
      jump_value = 26'h0100004; tick("jmp10");
      chk("jmp_pc10", 32'(read_addr), 32'h10);
      jump_value = 26'h5; branch = 1; zero = 1; se_imm = 32'hFFFFFFFF;
      tick("jmp_prio");
      chk("jmp_prio_pc", 32'(read_addr), 32'h14);
      clr_in(); jump = 1; jump_value = 26'h4; tick("back10");
      clr_in(); branch = 1; zero = 0; se_imm = 32'hFFFFFFFF; tick("br_nz");
      chk("br_nz_pc", 32'(read_addr), 32'h14);
      clr_in(); jump = 1; jump_value = 26'h4; tick("back10b");
      clr_in(); branch = 1; zero = 1; se_imm = 32'hFFFFFFFF; tick("spin");
      chk("spin_pc", 32'(read_addr), 32'h10);
      chk("spin_flag", 32'(spin_halt), 32'd1);
      chk("spin_state", 32'(state), 32'd2);
      chk("spin_en", 32'(core_en), 32'd0);
      clr_in(); jump = 1; jump_value = 26'h20; tick("halt_ign");
      chk("halt_hold_pc", 32'(read_addr), 32'h10);

      clr_in(); start = 1; tick("resume");
      chk("resume_spin", 32'(spin_halt), 32'd0);
      start = 0; jump = 1; jump_value = 26'h3F; tick("to_fc");
      chk("fc_pc", 32'(read_addr), 32'hFC);
      clr_in(); tick("wrap");
      chk("wrap_pc", 32'(read_addr), 32'h00);
      tick("w4"); tick("w8");
      halt_req = 1; start = 1; tick("hreq");
      chk("hreq_pc", 32'(read_addr), 32'h0C);
      chk("hreq_state", 32'(state), 32'd2);
      saved_cnt = m_cnt;
      clr_in(); tick("halted");
      start = 1; tick("restart");
      chk("restart_pc", 32'(read_addr), 32'h0C);
      chk("restart_cnt", 32'(instr_count), 32'(saved_cnt));
      start = 0; tick("run_on");

      reset_pulse("midrst");
      tick("post_rst");
      chk("post_rst_state", 32'(state), 32'd0);

      start = 1; tick("s_start");
      start = 0; halt_req = 1; tick("s_halt");
      halt_req = 0; step = 1;
      pulses = 0;
      tick("s_step"); pulses += int'(core_en);
      step = 0;
      tick("s_after1"); pulses += int'(core_en);
      tick("s_after2"); pulses += int'(core_en);
`ifdef MIPS_SEQ_STEP_EN
      chk("step_pulses", 32'(pulses), 32'd1);
      chk("step_pc", 32'(read_addr), 32'h08);
`else
      chk("step_pulses", 32'(pulses), 32'd0);
      chk("step_pc", 32'(read_addr), 32'h04);
`endif

      for (int i = 0; i < 600; i++) begin
         start      = ($urandom_range(0, 7) == 0);
         halt_req   = ($urandom_range(0, 9) == 0);
         step       = ($urandom_range(0, 5) == 0);
         branch     = ($urandom_range(0, 2) == 0);
         zero       = $urandom_range(0, 1) == 1;
         jump       = ($urandom_range(0, 4) == 0);
         se_imm     = 32'($signed($urandom_range(0, 6)) - 3);
         jump_value = 26'($urandom);
         if ($urandom_range(0, 99) == 0) reset_pulse("rnd_rst");
         tick("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
